// File: rtl/uart_frame_tx.sv
// uart_frame_tx: FIFO-buffered UART serialiser (5-8 data bits, 1-2 stop bits, parity under UART_TX_PARITY_EN).
// Latency: start bit begins two edges after a push into an idle block; queued frames follow with no idle gap.
// Backpressure: tx_ready drops while the FIFO holds FIFO_DEPTH words; a full FIFO refuses pushes even on a pop cycle.

// uart_tx_fifo: power-of-two word FIFO with registered occupancy count.
// Latency: a pushed word is visible at the head one edge later; pop_dat is the current head.
// Backpressure: push_rdy is low when full, independent of a same-cycle pop.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   push_rdy,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_fire, pop_fire;

  assign push_rdy  = (level_q != (AW+1)'(DEPTH));
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && (level_q != '0);
  assign pop_dat   = mem_q[rd_ptr_q];
  assign level     = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_fire, pop_fire})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: a flush only clears the pointers and count.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

module uart_frame_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W    = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 line_q, line_d;
  logic                 done_q, done_d;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 fifo_empty;
  logic                 baud_end;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push_vld (tx_valid),
    .push_dat (tx_data),
    .push_rdy (tx_ready),
    .pop_vld  (pop),
    .pop_dat  (head),
    .level    (fifo_level)
  );

  assign fifo_empty = (fifo_level == '0);
  assign baud_end   = (baud_q == BAUD_W'(BAUD_DIV - 1));

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  logic head_par;
  assign head_par = (^head) ^ (PARITY_ODD != 0);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = 1'b1;
    done_d  = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = head_par;
`endif
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        line_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        line_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        line_d = par_q;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        line_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            bit_d  = '0;
            // Chain straight into the next start bit when work is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head;
`ifdef UART_TX_PARITY_EN
              par_d   = head_par;
`endif
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Line and done trail the state by one edge, so busy also covers the done cycle.
  assign uart_tx = line_q;
  assign tx_done = done_q;
  assign tx_busy = (state_q != S_IDLE) || !fifo_empty || done_q;
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: default 8N1, a fast 8-bit/depth-4 instance and a 5-bit/2-stop instance.
module tb_uart_frame_tx;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk;
  logic rst_ac, rst_b;
  logic [7:0] a_data;  logic a_valid, a_ready, a_tx, a_busy, a_done; logic [4:0] a_level;
  logic [7:0] b_data;  logic b_valid, b_ready, b_tx, b_busy, b_done; logic [2:0] b_level;
  logic [4:0] c_data;  logic c_valid, c_ready, c_tx, c_busy, c_done; logic [2:0] c_level;

  int total, bad;
  int sel;
  logic mon_line, mon_done;
  int mon_level;
  logic [7:0] wq [8];
  int line_bad [9];
  int done_bad, done_cnt, peak;

`ifdef UART_TX_PARITY_EN
  logic single_exp [11] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1};
  logic narrow_exp [9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
  localparam int SINGLE_LEN = 4774;
  localparam int NARROW_LEN = 90;
  localparam logic PBIT_5A = 1'b0;
  localparam logic PBIT_43 = 1'b1;
`else
  logic single_exp [11] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
  logic narrow_exp [9]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
  localparam int SINGLE_LEN = 4340;
  localparam int NARROW_LEN = 80;
  localparam logic PBIT_5A = 1'b1;
  localparam logic PBIT_43 = 1'b1;
`endif

  uart_frame_tx dut_a (
    .Clk(clk), .Reset(rst_ac), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .uart_tx(a_tx), .tx_busy(a_busy), .tx_done(a_done), .fifo_level(a_level));

  uart_frame_tx #(.CLK_FREQ(100), .BAUD(10), .FIFO_DEPTH(4)) dut_b (
    .Clk(clk), .Reset(rst_b), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .uart_tx(b_tx), .tx_busy(b_busy), .tx_done(b_done), .fifo_level(b_level));

  uart_frame_tx #(.CLK_FREQ(100), .BAUD(10), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .Clk(clk), .Reset(rst_ac), .tx_data(c_data), .tx_valid(c_valid), .tx_ready(c_ready),
    .uart_tx(c_tx), .tx_busy(c_busy), .tx_done(c_done), .fifo_level(c_level));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mon_line  = (sel == 0) ? a_tx   : (sel == 1) ? b_tx   : c_tx;
  assign mon_done  = (sel == 0) ? a_done : (sel == 1) ? b_done : c_done;
  assign mon_level = (sel == 0) ? int'(a_level) : (sel == 1) ? int'(b_level) : int'(c_level);

  function automatic logic even_par(input logic [7:0] w, input int nb);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ w[i];
    return p;
  endfunction

  // Reference line model: first sample taken is cycle 1 of frame 0.
  task automatic watch(input int nf, input int extra, input int div, input int nb, input int ns);
    int L, tot, f, r, b;
    logic exp_l, exp_d;
    logic [7:0] w;
    L = (1 + nb + PAR + ns) * div;
    tot = nf * L + extra;
    for (int i = 0; i < 9; i++) line_bad[i] = 0;
    done_bad = 0; done_cnt = 0; peak = 0;
    for (int c = 0; c < tot; c++) begin
      @(negedge clk);
      f = c / L; r = c % L; b = r / div;
      exp_l = 1'b1; exp_d = 1'b0;
      if (f < nf) begin
        w = wq[f];
        exp_d = (r == L - 1);
        if (b == 0) exp_l = 1'b0;
        else if (b <= nb) begin w = w >> (b - 1); exp_l = w[0]; end
        else if (PAR == 1 && b == nb + 1) exp_l = even_par(wq[f], nb);
      end
      if (mon_line !== exp_l) line_bad[(f < nf) ? f : 8]++;
      if (mon_done === 1'b1) done_cnt++;
      if (mon_done !== exp_d) done_bad++;
      if (mon_level > peak) peak = mon_level;
    end
  endtask

  task automatic test_reset();
    rst_ac = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (a_tx !== 1'b1)   begin bad++; $display("FAIL reset_uart_tx got=%b want=1", a_tx); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", a_busy); end
    total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", a_done); end
    total++; if (a_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", a_level); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_ready); end
    total++; if ({b_tx, b_level, b_ready} !== 5'b1_000_1) begin bad++; $display("FAIL reset_b got=%b want=10001", {b_tx, b_level, b_ready}); end
    total++; if ({c_tx, c_level, c_ready, c_busy, c_done} !== 7'b1_000_1_0_0) begin bad++; $display("FAIL reset_c got=%b want=1000100", {c_tx, c_level, c_ready, c_busy, c_done}); end
    rst_ac = 1'b0; rst_b = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({a_tx, a_busy} !== 2'b10) begin bad++; $display("FAIL idle_after_reset got=%b want=10", {a_tx, a_busy}); end
  endtask

  task automatic test_single();
    int errs, ndone, done_at;
    sel = 0;
    a_data = 8'h5A; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0;
    total++; if (a_level !== 5'd1) begin bad++; $display("FAIL single_level_push got=%0d want=1", a_level); end
    total++; if (a_busy !== 1'b1)  begin bad++; $display("FAIL single_busy_push got=%b want=1", a_busy); end
    @(negedge clk);
    total++; if ({a_level, a_tx} !== 6'b00000_1) begin bad++; $display("FAIL single_pop got=%b want=000001", {a_level, a_tx}); end
    ndone = 0; done_at = -1;
    for (int b = 0; b < 10 + PAR; b++) begin
      errs = 0;
      for (int c = 0; c < 434; c++) begin
        @(negedge clk);
        if (a_tx !== single_exp[b]) errs++;
        if (a_done === 1'b1) begin ndone++; done_at = b * 434 + c; end
      end
      total++; if (errs != 0) begin bad++; $display("FAIL single_bit%0d wrong_cycles=%0d want_level=%b", b, errs, single_exp[b]); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", ndone); end
    total++; if (done_at + 1 != SINGLE_LEN) begin bad++; $display("FAIL single_done_cycle got=%0d want=%0d", done_at + 1, SINGLE_LEN); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL single_busy_done got=%b want=1", a_busy); end
    @(negedge clk);
    total++; if ({a_busy, a_done, a_tx} !== 3'b001) begin bad++; $display("FAIL single_after got=%b want=001", {a_busy, a_done, a_tx}); end
  endtask

  task automatic test_burst();
    sel = 0;
    wq = '{8'h5A, 8'h43, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'h00, 8'h00};
    fork
      begin
        for (int i = 0; i < 6; i++) begin a_data = wq[i]; a_valid = 1'b1; @(negedge clk); end
        a_valid = 1'b0;
      end
      begin
        @(negedge clk); @(negedge clk);
        watch(6, 5, 434, 8, 1);
      end
    join
    for (int f = 0; f < 6; f++) begin
      total++; if (line_bad[f] != 0) begin bad++; $display("FAIL burst_frame%0d wrong_cycles=%0d want=0", f, line_bad[f]); end
    end
    total++; if (line_bad[8] != 0) begin bad++; $display("FAIL burst_idle wrong_cycles=%0d want=0", line_bad[8]); end
    total++; if (done_cnt != 6) begin bad++; $display("FAIL burst_done_count got=%0d want=6", done_cnt); end
    total++; if (done_bad != 0) begin bad++; $display("FAIL burst_done_place wrong_cycles=%0d want=0", done_bad); end
    total++; if (peak > 6 || peak < 1) begin bad++; $display("FAIL burst_peak got=%0d want=1..6", peak); end
  endtask

  task automatic test_parity();
    logic pb [2];
    int d0, d1, L, mid;
    sel = 0;
    L = (10 + PAR) * 434;
    mid = 9 * 434 + 217;
    d0 = -1; d1 = -1; pb[0] = 1'bx; pb[1] = 1'bx;
    fork
      begin
        a_data = 8'h5A; a_valid = 1'b1; @(negedge clk);
        a_data = 8'h43; @(negedge clk);
        a_valid = 1'b0;
      end
      begin
        @(negedge clk); @(negedge clk);
        for (int c = 0; c < 2 * L + 2; c++) begin
          @(negedge clk);
          if (c < 2 * L && (c % L) == mid) pb[c / L] = a_tx;
          if (a_done === 1'b1) begin if (d0 < 0) d0 = c; else d1 = c; end
        end
      end
    join
    total++; if (pb[0] !== PBIT_5A) begin bad++; $display("FAIL parity_5a got=%b want=%b", pb[0], PBIT_5A); end
    total++; if (pb[1] !== PBIT_43) begin bad++; $display("FAIL parity_43 got=%b want=%b", pb[1], PBIT_43); end
    total++; if (d0 + 1 != SINGLE_LEN) begin bad++; $display("FAIL parity_len0 got=%0d want=%0d", d0 + 1, SINGLE_LEN); end
    total++; if (d1 - d0 != SINGLE_LEN) begin bad++; $display("FAIL parity_len1 got=%0d want=%0d", d1 - d0, SINGLE_LEN); end
  endtask

  task automatic test_fifo_full();
    int acc_n, rdy_bad, ord_bad;
    logic saw_low;
    logic [7:0] acc_w [8];
    sel = 1;
    acc_n = 0; rdy_bad = 0; ord_bad = 0; saw_low = 1'b0;
    wq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h00, 8'h00};
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          if (b_ready !== (b_level != 3'd4)) rdy_bad++;
          if (b_ready === 1'b0) saw_low = 1'b1;
          b_data = 8'(16 + i); b_valid = 1'b1;
          if (b_ready === 1'b1) begin
            if (acc_n < 8) acc_w[acc_n] = b_data;
            acc_n++;
          end
          @(negedge clk);
        end
        b_valid = 1'b0;
      end
      begin
        @(negedge clk); @(negedge clk);
        watch(5, 3, 10, 8, 1);
      end
    join
    for (int k = 0; k < 5 && k < acc_n; k++) if (acc_w[k] !== wq[k]) ord_bad++;
    total++; if (acc_n != 5) begin bad++; $display("FAIL full_accepted got=%0d want=5", acc_n); end
    total++; if (ord_bad != 0) begin bad++; $display("FAIL full_accept_order wrong=%0d want=0", ord_bad); end
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL full_ready_vs_level wrong=%0d want=0", rdy_bad); end
    total++; if (saw_low !== 1'b1) begin bad++; $display("FAIL full_ready_low got=%b want=1", saw_low); end
    total++; if (peak != 4) begin bad++; $display("FAIL full_peak got=%0d want=4", peak); end
    for (int f = 0; f < 5; f++) begin
      total++; if (line_bad[f] != 0) begin bad++; $display("FAIL full_frame%0d wrong_cycles=%0d want=0", f, line_bad[f]); end
    end
    total++; if (done_cnt != 5) begin bad++; $display("FAIL full_done_count got=%0d want=5", done_cnt); end
  endtask

  task automatic test_reset_mid();
    sel = 1;
    for (int i = 0; i < 3; i++) begin b_data = 8'(57 + i); b_valid = 1'b1; @(negedge clk); end
    b_valid = 1'b0;
    total++; if (b_level !== 3'd2) begin bad++; $display("FAIL mid_queued got=%0d want=2", b_level); end
    repeat (43) @(negedge clk);
    total++; if ({b_tx, b_busy} !== 2'b11) begin bad++; $display("FAIL mid_data_bit3 got=%b want=11", {b_tx, b_busy}); end
    rst_b = 1'b1;
    @(negedge clk);
    total++; if ({b_tx, b_level, b_busy, b_done, b_ready} !== 7'b1_000_0_0_1) begin bad++; $display("FAIL mid_reset got=%b want=1000001", {b_tx, b_level, b_busy, b_done, b_ready}); end
    rst_b = 1'b0;
    watch(0, 150, 10, 8, 1);
    total++; if (line_bad[8] != 0) begin bad++; $display("FAIL mid_idle wrong_cycles=%0d want=0", line_bad[8]); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", done_cnt); end
    b_data = 8'hA5; b_valid = 1'b1;
    @(negedge clk); b_valid = 1'b0;
    @(negedge clk);
    wq[0] = 8'hA5;
    watch(1, 3, 10, 8, 1);
    total++; if (line_bad[0] != 0) begin bad++; $display("FAIL mid_resend wrong_cycles=%0d want=0", line_bad[0]); end
    total++; if (done_cnt != 1 || done_bad != 0) begin bad++; $display("FAIL mid_resend_done got=%0d/%0d want=1/0", done_cnt, done_bad); end
  endtask

  task automatic test_narrow();
    int errs, ndone, done_at;
    sel = 2;
    c_data = 5'h15; c_valid = 1'b1;
    @(negedge clk); c_valid = 1'b0;
    @(negedge clk);
    ndone = 0; done_at = -1;
    for (int b = 0; b < 8 + PAR; b++) begin
      errs = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (c_tx !== narrow_exp[b]) errs++;
        if (c_done === 1'b1) begin ndone++; done_at = b * 10 + c; end
      end
      total++; if (errs != 0) begin bad++; $display("FAIL narrow_bit%0d wrong_cycles=%0d want_level=%b", b, errs, narrow_exp[b]); end
    end
    total++; if (ndone != 1 || done_at + 1 != NARROW_LEN) begin bad++; $display("FAIL narrow_len got=%0d (pulses=%0d) want=%0d", done_at + 1, ndone, NARROW_LEN); end
    @(negedge clk);
    total++; if ({c_tx, c_busy} !== 2'b10) begin bad++; $display("FAIL narrow_after got=%b want=10", {c_tx, c_busy}); end
  endtask

  initial begin
    total = 0; bad = 0; sel = 0;
    a_data = '0; a_valid = 1'b0;
    b_data = '0; b_valid = 1'b0;
    c_data = '0; c_valid = 1'b0;
    rst_ac = 1'b1; rst_b = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_parity();
    test_fifo_full();
    test_reset_mid();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
